samm_sched: RTL and testbench

Job scheduler and arbiter placed in front of one `samm` systolic matrix-multiply engine. It accepts operand jobs from two requesters over valid/ready handshakes and grants them round-robin. For each granted job it issues the one-cycle `In_Dv` launch, captures the engine result, and returns it with a tag. Between jobs it pulses the engine's reset so the engine is armed for the next launch. A watchdog converts a missing engine completion into an error response.

---
 rtl/samm_sched.sv | 162 ++++++++++++++++
 tb/tb_samm_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/samm_sched.sv
// rtl/samm_sched.sv - two-requester round-robin job scheduler in front of one samm engine
module samm_sched #(
  parameter int N       = 8,
  parameter int M       = 8,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 32,
  parameter int RST_CYC = 2
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Req0_Valid,
  output logic                 Req0_Ready,
  input  logic [2*M*N-1:0]     Req0_A,
  input  logic [TAG_W-1:0]     Req0_Tag,
  input  logic                 Req1_Valid,
  output logic                 Req1_Ready,
  input  logic [2*M*N-1:0]     Req1_A,
  input  logic [TAG_W-1:0]     Req1_Tag,
  output logic                 Res_Valid,
  input  logic                 Res_Ready,
  output logic [N*2*M*M-1:0]   Res_Data,
  output logic [TAG_W-1:0]     Res_Tag,
  output logic                 Res_Src,
  output logic                 Res_Err,
  output logic                 Eng_Rst_n,
  output logic                 Eng_In_Dv,
  output logic [2*M*N-1:0]     Eng_A,
  input  logic [N*2*M*M-1:0]   Eng_Out_data,
  input  logic                 Eng_Out_Dv,
  output logic                 Busy,
  output logic [15:0]          Job_Cnt
);
  localparam int AW = 2*M*N;
  localparam int DW = N*2*M*M;
  localparam int WW = $clog2(TIMEOUT);
  localparam int RW = $clog2(RST_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_ERST} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             src_q, src_d;
  logic [DW-1:0]    data_q, data_d;
  logic             err_q, err_d;
  logic [WW-1:0]    wdog_q, wdog_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [15:0]      job_cnt_q, job_cnt_d;
  logic             eng_rst_n_q, eng_rst_n_d;
  logic             eng_in_dv_q, eng_in_dv_d;
  logic [AW-1:0]    eng_a_q, eng_a_d;
  logic             gnt0, gnt1, idle;

  // On a tie the requester that did not win last time is granted.
  assign gnt0       = Req0_Valid & (~Req1_Valid | last_grant_q);
  assign gnt1       = Req1_Valid & (~Req0_Valid | ~last_grant_q);
  assign idle       = (state_q == S_IDLE);
  assign Req0_Ready = Rst_n & idle & gnt0;
  assign Req1_Ready = Rst_n & idle & gnt1;

  assign Res_Valid  = (state_q == S_HOLD);
  assign Res_Data   = data_q;
  assign Res_Tag    = tag_q;
  assign Res_Src    = src_q;
  assign Res_Err    = err_q;
  assign Eng_Rst_n  = eng_rst_n_q;
  assign Eng_In_Dv  = eng_in_dv_q;
  assign Eng_A      = eng_a_q;
  assign Busy       = ~idle;
  assign Job_Cnt    = job_cnt_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tag_d        = tag_q;
    src_d        = src_q;
    data_d       = data_q;
    err_d        = err_q;
    wdog_d       = wdog_q;
    rcnt_d       = rcnt_q;
    job_cnt_d    = job_cnt_q;
    eng_rst_n_d  = 1'b1;
    eng_in_dv_d  = 1'b0;
    eng_a_d      = '0;
    case (state_q)
      S_IDLE: begin
        if (Req0_Ready | Req1_Ready) begin
          tag_d        = Req1_Ready ? Req1_Tag : Req0_Tag;
          src_d        = Req1_Ready;
          last_grant_d = Req1_Ready;
          eng_in_dv_d  = 1'b1;
          eng_a_d      = Req1_Ready ? Req1_A : Req0_A;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // A real completion takes priority over a coincident timeout.
        if (Eng_Out_Dv) begin
          data_d  = Eng_Out_data;
          err_d   = 1'b0;
          state_d = S_HOLD;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (Res_Ready) begin
          job_cnt_d   = job_cnt_q + 16'd1;
          eng_rst_n_d = 1'b0;
          rcnt_d      = '0;
          state_d     = S_ERST;
        end
      end
      S_ERST: begin
        if (rcnt_q == RW'(RST_CYC - 1)) begin
          state_d = S_IDLE;
        end else begin
          rcnt_d      = rcnt_q + 1'b1;
          eng_rst_n_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      tag_q        <= '0;
      src_q        <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
      wdog_q       <= '0;
      rcnt_q       <= '0;
      job_cnt_q    <= '0;
      eng_rst_n_q  <= 1'b0;
      eng_in_dv_q  <= 1'b0;
      eng_a_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tag_q        <= tag_d;
      src_q        <= src_d;
      data_q       <= data_d;
      err_q        <= err_d;
      wdog_q       <= wdog_d;
      rcnt_q       <= rcnt_d;
      job_cnt_q    <= job_cnt_d;
      eng_rst_n_q  <= eng_rst_n_d;
      eng_in_dv_q  <= eng_in_dv_d;
      eng_a_q      <= eng_a_d;
    end
  end
endmodule

// File: tb/tb_samm_sched.sv
// tb/tb_samm_sched.sv - table-driven scoreboard bench for samm_sched with a behavioural engine
module tb_samm_sched;
  localparam int N = 8, M = 8, TAG_W = 4, TIMEOUT = 32, RST_CYC = 2;
  localparam int AW = 2*M*N, DW = N*2*M*M;

  logic Clk = 1'b0;
  logic Rst_n = 1'b1;
  logic Req0_Valid = 0, Req1_Valid = 0, Res_Ready = 0;
  logic [AW-1:0] Req0_A = '0, Req1_A = '0, Eng_A;
  logic [TAG_W-1:0] Req0_Tag = '0, Req1_Tag = '0, Res_Tag;
  logic Req0_Ready, Req1_Ready, Res_Valid, Res_Src, Res_Err;
  logic Eng_Rst_n, Eng_In_Dv, Eng_Out_Dv, Busy;
  logic [DW-1:0] Res_Data, Eng_Out_data;
  logic [15:0] Job_Cnt;

  logic model_dv = 0, spur_dv = 0, eng_on = 1;
  logic [DW-1:0] model_data = '0, spur_data = '0;
  logic [AW-1:0] model_a = '0;
  int model_cnt = 0;

  typedef struct { logic v0; logic v1; logic exp_src; logic eng_on; int bp; } vec_t;
  typedef struct { logic [DW-1:0] data; logic [TAG_W-1:0] tag; logic src; logic err; } exp_t;
  vec_t vecs[9];
  exp_t sb[$];
  int checks = 0, failures = 0;
  logic [15:0] exp_cnt = 0;

  assign Eng_Out_Dv   = model_dv | spur_dv;
  assign Eng_Out_data = spur_dv ? spur_data : model_data;

  samm_sched #(.N(N), .M(M), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_A(Req0_A), .Req0_Tag(Req0_Tag),
    .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_A(Req1_A), .Req1_Tag(Req1_Tag),
    .Res_Valid(Res_Valid), .Res_Ready(Res_Ready), .Res_Data(Res_Data), .Res_Tag(Res_Tag),
    .Res_Src(Res_Src), .Res_Err(Res_Err), .Eng_Rst_n(Eng_Rst_n), .Eng_In_Dv(Eng_In_Dv),
    .Eng_A(Eng_A), .Eng_Out_data(Eng_Out_data), .Eng_Out_Dv(Eng_Out_Dv), .Busy(Busy),
    .Job_Cnt(Job_Cnt)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] res_fn(input logic [AW-1:0] a);
    return {8{a}} ^ {32{32'hDEADBEEF}};
  endfunction

  // Engine: one-cycle Out_Dv exactly 3*M cycles after the In_Dv cycle.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      model_cnt = 0;
      model_dv  = 0;
    end else begin
      model_dv = 0;
      if (model_cnt > 0) begin
        model_cnt = model_cnt - 1;
        if (model_cnt == 0) model_dv = 1;
      end
      if (Eng_In_Dv && eng_on) begin
        model_cnt = 3*M;
        model_a   = Eng_A;
      end
    end
    model_data = model_dv ? res_fn(model_a) : '0;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual[127:0]=%0h expected[127:0]=%0h", name, act[127:0], exp[127:0]);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, {Req0_Ready, Req1_Ready}, 0);
    chk({tag, "_res_valid"}, Res_Valid, 0);
    chk_data({tag, "_res_data"}, Res_Data, '0);
    chk({tag, "_res_tag_src_err"}, {Res_Tag, Res_Src, Res_Err}, 0);
    chk({tag, "_eng_rst_dv"}, {Eng_Rst_n, Eng_In_Dv}, 0);
    chk({tag, "_eng_a"}, Eng_A, 0);
    chk({tag, "_busy_cnt"}, {Busy, Job_Cnt}, 0);
  endtask

  // Entered and left at a negedge in an IDLE cycle.
  task automatic run_job(input vec_t v, input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1);
    logic [AW-1:0] a0, a1, ag;
    logic src;
    int k, lat, low;
    exp_t e, snap, got;
    a0 = {$urandom, $urandom, $urandom, $urandom};
    a1 = {$urandom, $urandom, $urandom, $urandom};
    eng_on = v.eng_on;
    Req0_Valid = v.v0; Req0_A = a0; Req0_Tag = t0;
    Req1_Valid = v.v1; Req1_A = a1; Req1_Tag = t1;
    #1;
    for (k = 0; k < 50 && !(Req0_Ready || Req1_Ready); k++) begin
      @(negedge Clk); #1;
    end
    if (!(Req0_Ready || Req1_Ready)) begin
      chk("handshake_timeout", 1, 0);
      Req0_Valid = 0; Req1_Valid = 0;
      return;
    end
    src = Req1_Ready;
    chk("grant_src", src, v.exp_src);
    chk("other_ready_low", src ? Req0_Ready : Req1_Ready, 0);
    ag = src ? a1 : a0;
    e.data = v.eng_on ? res_fn(ag) : '0;
    e.tag  = src ? t1 : t0;
    e.src  = src;
    e.err  = !v.eng_on;
    sb.push_back(e);
    @(negedge Clk);
    Req0_Valid = 0; Req1_Valid = 0;
    chk("issue_dv_busy", {Eng_In_Dv, Busy}, 2'b11);
    chk("issue_eng_a", Eng_A, ag);
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
      if (lat == 1) chk("dv_one_cycle", {Eng_In_Dv, Eng_A}, 0);
    end while (!Res_Valid && lat < 200);
    chk("res_latency", lat, v.eng_on ? 3*M + 1 : TIMEOUT + 1);
    snap.data = Res_Data; snap.tag = Res_Tag; snap.src = Res_Src; snap.err = Res_Err;
    for (int b = 0; b < v.bp; b++) begin
      if (b == 1) begin spur_dv = 1; spur_data = ~'0; end
      if (b == 2) spur_dv = 0;
      @(negedge Clk);
      chk("bp_hold_valid_rst", {Res_Valid, Eng_Rst_n}, 2'b11);
      chk_data("bp_data_stable", Res_Data, snap.data);
      chk("bp_fields_stable", {Res_Tag, Res_Src, Res_Err}, {snap.tag, snap.src, snap.err});
    end
    spur_dv = 0;
    Res_Ready = 1;
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      got = sb.pop_front();
      chk_data("res_data", Res_Data, got.data);
      chk("res_tag_src_err", {Res_Tag, Res_Src, Res_Err}, {got.tag, got.src, got.err});
    end
    exp_cnt = exp_cnt + 16'd1;
    @(negedge Clk);
    Res_Ready = 0;
    low = 0;
    while (!Eng_Rst_n && low < 20) begin
      low++;
      @(negedge Clk);
    end
    chk("eng_rst_cycles", low, RST_CYC);
    chk("job_cnt", Job_Cnt, exp_cnt);
    chk("idle_busy_res_valid", {Busy, Res_Valid}, 0);
  endtask

  initial begin
    vecs[0] = '{1, 0, 0, 1, 0};
    vecs[1] = '{0, 1, 1, 1, 0};
    vecs[2] = '{1, 1, 0, 1, 0};
    vecs[3] = '{1, 1, 1, 1, 0};
    vecs[4] = '{1, 1, 0, 1, 0};
    vecs[5] = '{1, 1, 1, 1, 0};
    vecs[6] = '{0, 1, 1, 1, 5};
    vecs[7] = '{1, 0, 0, 0, 0};
    vecs[8] = '{1, 0, 0, 1, 0};

    #2 Rst_n = 0;
    Req0_Valid = 1;
    #1 chk_all_zero("reset");
    Req0_Valid = 0;
    repeat (2) @(negedge Clk);
    Rst_n = 1;
    @(negedge Clk);
    chk("eng_rst_release", Eng_Rst_n, 1);

    for (int i = 0; i < 9; i++)
      run_job(vecs[i], TAG_W'(5 + i), TAG_W'(10 + i));

    // Reset in the third WAIT cycle drops the job silently.
    Req0_Valid = 1; Req0_A = {4{32'h0BAD_F00D}}; Req0_Tag = 4'd7;
    @(negedge Clk);
    Req0_Valid = 0;
    repeat (3) @(negedge Clk);
    Rst_n = 0;
    Req1_Valid = 1;
    #1 chk_all_zero("mid_reset");
    Req1_Valid = 0;
    repeat (2) @(negedge Clk);
    Rst_n = 1;
    exp_cnt = 0;
    @(negedge Clk);
    chk("post_reset_eng_rst", {Eng_Rst_n, Res_Valid}, 2'b10);
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (Res_Valid) begin
        chk("dropped_job_response", Res_Valid, 0);
        break;
      end
    end
    run_job('{0, 1, 1, 1, 0}, 4'd2, 4'd9);

    force dut.job_cnt_q = 16'hFFFF;
    @(negedge Clk);
    release dut.job_cnt_q;
    @(negedge Clk);
    chk("preload_cnt", Job_Cnt, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    run_job('{1, 0, 0, 1, 0}, 4'd3, 4'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
